// File: rtl/mdu_issue_scheduler.sv
// mdu_issue_scheduler: two-requester issue arbiter for a shared multiply/divide
// unit. It tracks the MDU's single writeback port with a reservation shift
// vector. Each op claims two consecutive writeback slots (Hi, then Lo). An op
// is accepted only when both of its slots are free. Two requesters are served
// round-robin.
//
// Optional feature: define MDU_DIV_SERIAL_EN to model a non-pipelined divider.
// A div is then accepted only when no earlier div is still in flight. Mul ops
// are not affected by this option.
//
// Handshake: req_valid[i] presents an op from requester i. req_grant[i] is a
// same-cycle, combinational acceptance. An op counts as issued in exactly the
// cycle where req_valid[i] and req_grant[i] are both high. A requester that
// is not granted keeps its request asserted and retries in a later cycle.

module mdu_issue_scheduler #(
   parameter int MUL_LAT = 5,   // issue -> Hi writeback for mult/multu
   parameter int DIV_LAT = 20   // issue -> Hi writeback for div/divu, > MUL_LAT+1
) (
   input  logic       clk,
   input  logic       rst,          // asynchronous, active-low
   input  logic       flush,        // synchronous, active-high
   input  logic [1:0] req_valid,
   input  logic [1:0] req_is_div,
   output logic [1:0] req_grant,
   output logic       issue_valid,
   output logic       issue_sel,
   output logic       issue_is_div,
   output logic       wb_busy,
   output logic       div_inflight
);

   localparam int RW = DIV_LAT + 2;
   localparam int CW = $clog2(DIV_LAT + 2);

   // The new op's two slots are written one position lower because the
   // whole vector shifts down by one on the same edge.
   localparam logic [RW-1:0] MUL_MASK = RW'(3) << (MUL_LAT - 1);
   localparam logic [RW-1:0] DIV_MASK = RW'(3) << (DIV_LAT - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT + 1);

   logic [RW-1:0] resv;       // resv[k]: writeback port busy k cycles from now
   logic [CW-1:0] div_cnt;    // cycles left until the newest div's Lo writeback
   logic          rr;         // preferred requester
   logic [1:0]    fits;
   logic [1:0]    div_ok;
   logic [1:0]    elig;
   logic [RW-1:0] new_bits;

   // Slot fit per requester: both target writeback cycles must be free.
   always_comb begin
      fits = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (req_is_div[i]) begin
            fits[i] = ~resv[DIV_LAT] & ~resv[DIV_LAT+1];
         end else begin
            fits[i] = ~resv[MUL_LAT] & ~resv[MUL_LAT+1];
         end
      end
   end

`ifdef MDU_DIV_SERIAL_EN
   // A serial divider accepts a new div only after the previous one has
   // written back Lo.
   assign div_ok = ~req_is_div | {2{div_cnt == '0}};
`else
   assign div_ok = 2'b11;
`endif

   // Reset and flush suppress every grant.
   assign elig = req_valid & fits & div_ok & {2{rst & ~flush}};

   // Round-robin pick: the preferred requester first, then the other one.
   always_comb begin
      req_grant = 2'b00;
      if (elig[rr]) begin
         req_grant[rr] = 1'b1;
      end else if (elig[~rr]) begin
         req_grant[~rr] = 1'b1;
      end
   end

   assign issue_valid  = |req_grant;
   assign issue_sel    = req_grant[1];
   assign issue_is_div = issue_valid & req_is_div[issue_sel];
   assign new_bits     = issue_valid ? (issue_is_div ? DIV_MASK : MUL_MASK) : '0;

   assign wb_busy      = resv[0];
   // The issue cycle itself counts as in flight. The counter covers the
   // cycles after issue, through the Lo writeback.
   assign div_inflight = (div_cnt != '0) | issue_is_div;

   // Reservation vector: shift one slot per cycle and add the new op's slots.
   // A flush drops all outstanding reservations.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resv <= '0;
      end else if (flush) begin
         resv <= '0;
      end else begin
         resv <= (resv >> 1) | new_bits;
      end
   end

   // Div tracking: reload on each div issue. The newest div always finishes
   // last, so reloading never shortens the in-flight window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (flush) begin
         div_cnt <= '0;
      end else if (issue_is_div) begin
         div_cnt <= DIV_LOAD;
      end else if (div_cnt != '0) begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

   // Round-robin pointer: after a grant it moves to the other requester, and
   // it holds when nothing is granted. Flush leaves it untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr <= 1'b0;
      end else if (issue_valid) begin
         rr <= ~issue_sel;
      end
   end

endmodule

// File: tb/tb_mdu_issue_scheduler.sv
// tb_mdu_issue_scheduler: directed scenarios followed by randomized traffic.
// The reference model keeps writeback occupancy as a table indexed by
// absolute cycle number. It keeps div lifetime as the absolute cycle of the
// newest div's Lo writeback.
// Build with +define+MDU_DIV_SERIAL_EN to check the serial-divider variant.

module tb_mdu_issue_scheduler;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 20;
   localparam int OCC_N   = 8192;
`ifdef MDU_DIV_SERIAL_EN
   localparam int SECOND_DIV_CYCLE = DIV_LAT + 2;
`else
   localparam int SECOND_DIV_CYCLE = 2;
`endif

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush = 1'b0;
   logic [1:0] req_valid = 2'b00;
   logic [1:0] req_is_div = 2'b00;
   logic [1:0] req_grant;
   logic       issue_valid;
   logic       issue_sel;
   logic       issue_is_div;
   logic       wb_busy;
   logic       div_inflight;

   always #5 clk = ~clk;

   mdu_issue_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_is_div   (req_is_div),
      .req_grant    (req_grant),
      .issue_valid  (issue_valid),
      .issue_sel    (issue_sel),
      .issue_is_div (issue_is_div),
      .wb_busy      (wb_busy),
      .div_inflight (div_inflight)
   );

   // ---------------- scoreboard state ----------------
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   occ [0:OCC_N-1];   // occ[c]: writeback port used in absolute cycle c
   int   cyc      = 0;      // absolute cycle number of the cycle being checked
   int   m_div_lo = -1;     // Lo writeback cycle of the newest div
   logic m_rr     = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- driver + model ----------------
   // Runs one clocked cycle with reset released. Returns the observed grant.
   task automatic step(input logic [1:0] v, input logic [1:0] d, input logic f,
                       output logic [1:0] g_obs);
      logic [1:0] ok;
      logic [1:0] g;
      logic       sel;
      logic       exp_div;
      int         lat;
      @(posedge clk);
      #1;
      rst        = 1'b1;
      req_valid  = v;
      req_is_div = d;
      flush      = f;
      @(negedge clk);
      ok = 2'b00;
      for (int i = 0; i < 2; i++) begin
         lat   = d[i] ? DIV_LAT : MUL_LAT;
         ok[i] = v[i] && !f && !occ[cyc+lat] && !occ[cyc+lat+1];
`ifdef MDU_DIV_SERIAL_EN
         if (d[i] && m_div_lo >= cyc) ok[i] = 1'b0;
`endif
      end
      g = 2'b00;
      if (ok[m_rr]) g[m_rr] = 1'b1;
      else if (ok[~m_rr]) g[~m_rr] = 1'b1;
      sel     = g[1];
      exp_div = (g != 2'b00) && d[sel];
      chk("grant",        req_grant,    g);
      chk("issue_valid",  issue_valid,  g != 2'b00);
      chk("issue_sel",    issue_sel,    sel);
      chk("issue_is_div", issue_is_div, exp_div);
      chk("wb_busy",      wb_busy,      occ[cyc]);
      chk("div_inflight", div_inflight, (m_div_lo >= cyc) || exp_div);
      g_obs = req_grant;
      if (g != 2'b00) begin
         lat = exp_div ? DIV_LAT : MUL_LAT;
         occ[cyc+lat]   = 1'b1;
         occ[cyc+lat+1] = 1'b1;
         if (exp_div) m_div_lo = cyc + DIV_LAT + 1;
         m_rr = ~sel;
      end
      if (f) begin
         for (int k = cyc + 1; k <= cyc + DIV_LAT + 2; k++) occ[k] = 1'b0;
         m_div_lo = -1;
      end
      cyc++;
   endtask

   // Holds reset low for n cycles with random request inputs. The next step()
   // releases it.
   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rst        = 1'b0;
         req_valid  = 2'($urandom_range(0, 3));
         req_is_div = 2'($urandom_range(0, 3));
         flush      = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("rst_grant",        req_grant,    2'b00);
         chk("rst_issue_valid",  issue_valid,  1'b0);
         chk("rst_issue_sel",    issue_sel,    1'b0);
         chk("rst_issue_is_div", issue_is_div, 1'b0);
         chk("rst_wb_busy",      wb_busy,      1'b0);
         chk("rst_div_inflight", div_inflight, 1'b0);
         for (int k = cyc; k <= cyc + DIV_LAT + 3; k++) occ[k] = 1'b0;
         m_div_lo = -1;
         m_rr     = 1'b0;
         cyc++;
      end
   endtask

   task automatic idle(input int n);
      logic [1:0] g;
      for (int i = 0; i < n; i++) step(2'b00, 2'b00, 1'b0, g);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] g;
      logic [1:0] exp_alt [0:5];
      logic       wb_seen [0:9];
      int         first;

      do_reset(3);

      // Single mul: granted at once, Hi/Lo writeback in cycles 5 and 6.
      step(2'b01, 2'b00, 1'b0, g);
      chk("mul_grant_c0", g, 2'b01);
      for (int k = 1; k < 10; k++) begin
         step(2'b00, 2'b00, 1'b0, g);
         wb_seen[k] = wb_busy;
      end
      chk("mul_wb_c4", wb_seen[4], 1'b0);
      chk("mul_wb_c5", wb_seen[5], 1'b1);
      chk("mul_wb_c6", wb_seen[6], 1'b1);
      chk("mul_wb_c7", wb_seen[7], 1'b0);

      // Div at cycle 0, then mul from cycle 15: blocked until cycle 17.
      do_reset(1);
      step(2'b01, 2'b01, 1'b0, g);
      chk("div_grant_c0", g, 2'b01);
      idle(14);
      step(2'b01, 2'b00, 1'b0, g);
      chk("mul_blocked_c15", g, 2'b00);
      step(2'b01, 2'b00, 1'b0, g);
      chk("mul_blocked_c16", g, 2'b00);
      step(2'b01, 2'b00, 1'b0, g);
      chk("mul_grant_c17", g, 2'b01);
      idle(DIV_LAT + 3);

      // Both requesters keep a mul pending: grants alternate, one every other cycle.
      do_reset(1);
      exp_alt[0] = 2'b01; exp_alt[1] = 2'b00; exp_alt[2] = 2'b10;
      exp_alt[3] = 2'b00; exp_alt[4] = 2'b01; exp_alt[5] = 2'b00;
      for (int k = 0; k < 6; k++) begin
         step(2'b11, 2'b00, 1'b0, g);
         chk($sformatf("alt_grant_c%0d", k), g, exp_alt[k]);
      end
      idle(DIV_LAT + 3);

      // req0 mul blocked, req1 div fits: req1 wins and the pointer stays at 0.
      do_reset(1);
      step(2'b10, 2'b00, 1'b0, g);
      chk("pre_mul_req1", g, 2'b10);
      step(2'b11, 2'b10, 1'b0, g);
      chk("div_req1_bypass", g, 2'b10);
      step(2'b11, 2'b00, 1'b0, g);
      chk("rr_back_to_0", g, 2'b01);
      idle(DIV_LAT + 3);

      // Flush in flight: no grant in the flush cycle, everything clear the next.
      do_reset(1);
      step(2'b01, 2'b01, 1'b0, g);
      idle(2);
      step(2'b01, 2'b00, 1'b1, g);
      chk("flush_no_grant", g, 2'b00);
      step(2'b01, 2'b00, 1'b0, g);
      chk("post_flush_grant", g, 2'b01);
      chk("post_flush_div_inflight", div_inflight, 1'b0);
      idle(DIV_LAT + 3);

      // Back-to-back divs from one requester: cycle of the second grant.
      do_reset(1);
      step(2'b01, 2'b01, 1'b0, g);
      chk("div_pair_first", g, 2'b01);
      first = -1;
      for (int k = 1; k < 40; k++) begin
         step(2'b01, 2'b01, 1'b0, g);
         if (g[0] && first < 0) first = k;
      end
      chk("div_pair_second_cycle", first, SECOND_DIV_CYCLE);
      idle(DIV_LAT + 3);

      // Randomized traffic, with occasional flushes and mid-run resets.
      do_reset(1);
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset(int'($urandom_range(1, 3)));
         end else begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 29) == 0), g);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
